// File: rtl/flash_blink_ctrl.sv
// Blink-phase and colour-cycle controller driven by the flash-clock divider tick.
// Produces registered flash_on / color_idx / cycle_done for the VGA pixel generator.
module flash_blink_ctrl #(
  parameter  int ON_TICKS  = 8,
  parameter  int OFF_TICKS = 8,
  parameter  int NCOLORS   = 8,
  localparam int MAX_TICKS = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS,
  localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1,
  localparam int IDX_W     = (NCOLORS > 1) ? $clog2(NCOLORS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             hold,
  input  logic             tick,
  output logic             flash_on,
  output logic [IDX_W-1:0] color_idx,
  output logic             cycle_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_TICKS - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_TICKS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCOLORS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flash_q, flash_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;

  wire advance = tick && !hold;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    flash_d = flash_q;
    idx_d   = idx_q;
    done_d  = 1'b0;

    if (!enable) begin
      // Dropping out of blinking beats any tick on the same edge; colour is kept.
      state_d = ST_IDLE;
      cnt_d   = '0;
      flash_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          flash_d = 1'b0;
          if (!hold) begin
            state_d = ST_ON;
            cnt_d   = '0;
            flash_d = 1'b1;
          end
        end
        ST_ON: begin
          if (advance) begin
            if (cnt_q == ON_LAST) begin
              state_d = ST_OFF;
              cnt_d   = '0;
              flash_d = 1'b0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_OFF: begin
          if (advance) begin
            if (cnt_q == OFF_LAST) begin
              state_d = ST_ON;
              cnt_d   = '0;
              flash_d = 1'b1;
              if (idx_q == IDX_LAST) begin
                idx_d  = '0;
                done_d = 1'b1;
              end else begin
                idx_d = idx_q + IDX_W'(1);
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          flash_d = 1'b0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      flash_q <= 1'b0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flash_q <= flash_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign flash_on   = flash_q;
  assign color_idx  = idx_q;
  assign cycle_done = done_q;

endmodule

// File: tb/tb_flash_blink_ctrl.sv
// Self-checking bench: two parameterisations share one stimulus stream and are
// compared each cycle against a period-position reference model.
module tb_flash_blink_ctrl;

  logic clk = 1'b0;
  logic reset, enable, hold, tick;

  logic       fo_a, done_a, fo_b, done_b;
  logic [1:0] ci_a;
  logic [0:0] ci_b;

  always #5 clk = ~clk;

  flash_blink_ctrl #(.ON_TICKS(2), .OFF_TICKS(3), .NCOLORS(4)) u_dut_a (
    .clk(clk), .reset(reset), .enable(enable), .hold(hold), .tick(tick),
    .flash_on(fo_a), .color_idx(ci_a), .cycle_done(done_a)
  );

  flash_blink_ctrl #(.ON_TICKS(1), .OFF_TICKS(1), .NCOLORS(2)) u_dut_b (
    .clk(clk), .reset(reset), .enable(enable), .hold(hold), .tick(tick),
    .flash_on(fo_b), .color_idx(ci_b), .cycle_done(done_b)
  );

  // Reference model: position inside one ON+OFF period, in ticks.
  int on_t[2]  = '{2, 1};
  int off_t[2] = '{3, 1};
  int ncol[2]  = '{4, 2};
  bit act[2];
  int pos[2];
  int col[2];
  bit done[2];

  int checks = 0;
  int errors = 0;

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      done[k] = 1'b0;
      if (!reset) begin
        act[k] = 1'b0; pos[k] = 0; col[k] = 0;
      end else if (!enable) begin
        act[k] = 1'b0; pos[k] = 0;
      end else if (!act[k]) begin
        if (!hold) begin act[k] = 1'b1; pos[k] = 0; end
      end else if (tick && !hold) begin
        pos[k]++;
        if (pos[k] == on_t[k] + off_t[k]) begin
          pos[k]  = 0;
          col[k]  = (col[k] + 1) % ncol[k];
          done[k] = (col[k] == 0);
        end
      end
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int exp_fo;
    for (int k = 0; k < 2; k++) begin
      exp_fo = (act[k] && pos[k] < on_t[k]) ? 1 : 0;
      if (k == 0) begin
        check({tag, "/a.flash_on"},   int'(fo_a),   exp_fo);
        check({tag, "/a.color_idx"},  int'(ci_a),   col[k]);
        check({tag, "/a.cycle_done"}, int'(done_a), int'(done[k]));
      end else begin
        check({tag, "/b.flash_on"},   int'(fo_b),   exp_fo);
        check({tag, "/b.color_idx"},  int'(ci_b),   col[k]);
        check({tag, "/b.cycle_done"}, int'(done_b), int'(done[k]));
      end
    end
  endtask

  // One clock: inputs already driven; model follows the edge; sample 1 ns later.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input bit r, input bit e, input bit h, input bit t);
    reset = r; enable = e; hold = h; tick = t;
  endtask

  initial begin
    bit found;
    for (int k = 0; k < 2; k++) begin act[k] = 0; pos[k] = 0; col[k] = 0; done[k] = 0; end

    // 1: reset wins over enable and tick
    drive(0, 1, 0, 1);
    repeat (3) cycle("reset");

    // 2: tick every 4 clocks through one full period
    drive(1, 1, 0, 0);
    cycle("start");
    for (int i = 0; i < 20; i++) begin
      tick = (i % 4 == 3);
      cycle("slow_tick");
    end

    // 3: tick every clock across several wraps of the colour index
    tick = 1;
    repeat (25) cycle("fast_tick");

    // 4: hold with ticks arriving, then release
    tick = 0;
    for (int i = 0; i < 10 && !(pos[0] == 1); i++) cycle("align_on");
    drive(1, 1, 1, 1);
    repeat (3) cycle("hold");
    drive(1, 1, 0, 1);
    repeat (6) cycle("hold_release");

    // 5: enable drop on the last OFF tick
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (pos[0] == on_t[0] + off_t[0] - 1) begin found = 1; break; end
      cycle("to_off_last");
    end
    check("reach_off_last", int'(found), 1);
    drive(1, 0, 0, 1);
    cycle("disable_on_wrap");
    drive(1, 0, 0, 0);
    cycle("idle");
    drive(1, 1, 0, 0);
    cycle("reenable");
    tick = 1;
    repeat (4) cycle("reenable_run");

    // 6: reset mid-OFF with a tick on the same edge
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (pos[0] >= on_t[0]) begin found = 1; break; end
      cycle("to_off");
    end
    check("reach_off", int'(found), 1);
    drive(0, 1, 0, 1);
    cycle("reset_mid_off");
    drive(1, 1, 0, 1);
    repeat (3) cycle("post_reset");

    // Randomised run
    for (int i = 0; i < 400; i++) begin
      reset  = ($urandom % 80) != 0;
      enable = ($urandom % 25) != 0;
      tick   = ($urandom % 3) == 0;
      hold   = act[0] ? (($urandom % 6) == 0) : 1'b0;
      cycle("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
